// File: rtl/coh_msg_tx_pkg.sv
// Shared definitions for the coherence message transmitter: address and
// message-type widths, message type codes, FSM state encoding and the
// queued message record.
package coh_msg_tx_pkg;

  localparam int ADDRWIDTH    = 8;
  localparam int MSGTYPEWIDTH = 2;

  localparam logic [MSGTYPEWIDTH-1:0] MSG_NONE = 2'd0;
  localparam logic [MSGTYPEWIDTH-1:0] MSG_RM   = 2'd1;
  localparam logic [MSGTYPEWIDTH-1:0] MSG_WM   = 2'd2;
  localparam logic [MSGTYPEWIDTH-1:0] MSG_INV  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [ADDRWIDTH-1:0]    addr;
    logic [MSGTYPEWIDTH-1:0] mtype;
  } coh_msg_t;

  // Read and write misses wait for the peer's acknowledge; invalidates do not.
  function automatic logic needs_ack(input logic [MSGTYPEWIDTH-1:0] t);
    return (t == MSG_RM) || (t == MSG_WM);
  endfunction

endpackage

// File: rtl/coh_msg_fifo.sv
// DEPTH-entry request FIFO of {addr, type} records. Push is ignored when
// full and pop is ignored when empty; push and pop may share a cycle.
module coh_msg_fifo
  import coh_msg_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  coh_msg_t push_data,
  input  logic     pop,
  output coh_msg_t head,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  coh_msg_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/coh_msg_tx.sv
// Coherence message transmitter: queues read-miss / write-miss / invalidate
// requests and presents them one at a time to the peer cache, with a
// one-cycle quiet gap between messages.
// Optional build macro COH_TX_TIMEOUT_EN adds an ack-wait limit of TIMEOUT
// cycles for RM/WM messages; without it the wait is unbounded.
//
// Request handshake: a request is accepted on any rising edge where
// reqValid && reqReady. reqReady depends only on FIFO occupancy (never on
// reqValid or on a same-cycle pop). An accepted request with type MSG_NONE
// is consumed without being queued.
module coh_msg_tx
  import coh_msg_tx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [ADDRWIDTH-1:0]    reqAddr,
  input  logic [MSGTYPEWIDTH-1:0] reqType,
  output logic                    havMsgToCache,
  output logic [ADDRWIDTH-1:0]    addrToCache,
  output logic                    rmToCache,
  output logic                    wmToCache,
  output logic                    invToCache,
  input  logic                    allowReadFromCache,
  output logic                    doneValid,
  output logic [MSGTYPEWIDTH-1:0] doneType,
  output logic                    timeoutErr,
  output tx_state_e               dbg_state
);

  tx_state_e               state_q, state_n;
  logic                    have_q, have_n;
  logic [ADDRWIDTH-1:0]    addr_q, addr_n;
  logic [MSGTYPEWIDTH-1:0] type_q, type_n;
  logic                    done_valid_q, done_valid_n;
  logic [MSGTYPEWIDTH-1:0] done_type_q, done_type_n;
  logic                    timeout_err_q, timeout_err_n;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  coh_msg_t                fifo_head;
  coh_msg_t                push_data;

`ifdef COH_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0]           cnt_q, cnt_n;
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  assign reqReady       = !fifo_full;
  assign fifo_push      = reqValid && !fifo_full && (reqType != MSG_NONE);
  assign push_data.addr  = reqAddr;
  assign push_data.mtype = reqType;

  coh_msg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Type flags are derived from the held type so they can never be high without havMsgToCache.
  assign havMsgToCache = have_q;
  assign addrToCache   = addr_q;
  assign rmToCache     = have_q && (type_q == MSG_RM);
  assign wmToCache     = have_q && (type_q == MSG_WM);
  assign invToCache    = have_q && (type_q == MSG_INV);
  assign doneValid     = done_valid_q;
  assign doneType      = done_type_q;
  assign timeoutErr    = timeout_err_q;
  assign dbg_state     = state_q;

  // Next-state and next-output decode: load on IDLE/GAP, complete or keep waiting in SEND.
  always_comb begin
    state_n       = state_q;
    have_n        = have_q;
    addr_n        = addr_q;
    type_n        = type_q;
    done_valid_n  = 1'b0;
    done_type_n   = done_type_q;
    timeout_err_n = 1'b0;
    fifo_pop      = 1'b0;
`ifdef COH_TX_TIMEOUT_EN
    cnt_n         = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_GAP: begin
        have_n  = 1'b0;
        state_n = ST_IDLE;
        if (!fifo_empty) begin
          state_n = ST_SEND;
          have_n  = 1'b1;
          addr_n  = fifo_head.addr;
          type_n  = fifo_head.mtype;
`ifdef COH_TX_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      ST_SEND: begin
        if (!needs_ack(type_q) || allowReadFromCache) begin
          fifo_pop     = 1'b1;
          have_n       = 1'b0;
          done_valid_n = 1'b1;
          done_type_n  = type_q;
          state_n      = ST_GAP;
        end
`ifdef COH_TX_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT - 1)) begin
          fifo_pop      = 1'b1;
          have_n        = 1'b0;
          timeout_err_n = 1'b1;
          state_n       = ST_GAP;
        end else begin
          cnt_n = cnt_q + TW'(1);
        end
`endif
      end
      default: begin
        state_n = ST_IDLE;
        have_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight message silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      have_q        <= 1'b0;
      addr_q        <= '0;
      type_q        <= MSG_NONE;
      done_valid_q  <= 1'b0;
      done_type_q   <= MSG_NONE;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      have_q        <= have_n;
      addr_q        <= addr_n;
      type_q        <= type_n;
      done_valid_q  <= done_valid_n;
      done_type_q   <= done_type_n;
      timeout_err_q <= timeout_err_n;
    end
  end

`ifdef COH_TX_TIMEOUT_EN
  // Ack-wait counter, restarted whenever a message is loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_coh_msg_tx.sv
// Bench for coh_msg_tx: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level model of the message channel.
module tb_coh_msg_tx;
  import coh_msg_tx_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int MW      = ADDRWIDTH + MSGTYPEWIDTH;
`ifdef COH_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                    reqValid = 1'b0;
  logic                    reqReady;
  logic [ADDRWIDTH-1:0]    reqAddr = '0;
  logic [MSGTYPEWIDTH-1:0] reqType = '0;
  logic                    havMsgToCache;
  logic [ADDRWIDTH-1:0]    addrToCache;
  logic                    rmToCache, wmToCache, invToCache;
  logic                    allowReadFromCache = 1'b0;
  logic                    doneValid;
  logic [MSGTYPEWIDTH-1:0] doneType;
  logic                    timeoutErr;
  tx_state_e               dbg_state;

  coh_msg_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .reset              (reset),
    .reqValid           (reqValid),
    .reqReady           (reqReady),
    .reqAddr            (reqAddr),
    .reqType            (reqType),
    .havMsgToCache      (havMsgToCache),
    .addrToCache        (addrToCache),
    .rmToCache          (rmToCache),
    .wmToCache          (wmToCache),
    .invToCache         (invToCache),
    .allowReadFromCache (allowReadFromCache),
    .doneValid          (doneValid),
    .doneType           (doneType),
    .timeoutErr         (timeoutErr),
    .dbg_state          (dbg_state)
  );

  // scoreboard: accepted-but-not-finished messages, head is the one on the wire
  logic [MW-1:0]           exp_q[$];
  bit                      m_on;
  logic [MW-1:0]           m_cur;
  int                      m_age;
  logic [ADDRWIDTH-1:0]    m_addr;
  bit                      m_done;
  logic [MSGTYPEWIDTH-1:0] m_done_type;
  bit                      m_to;
  int                      hi_cnt;
  int                      n_cmp = 0;
  int                      n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_on = 0; m_cur = '0; m_age = 0; m_addr = '0;
    m_done = 0; m_done_type = '0; m_to = 0;
  endtask

  task automatic check_outputs();
    logic [MSGTYPEWIDTH-1:0] t;
    t = m_cur[MSGTYPEWIDTH-1:0];
    chk("reqReady", reqReady, exp_q.size() < DEPTH);
    chk("havMsg", havMsgToCache, m_on);
    chk("addr", addrToCache, m_addr);
    chk("rm_flag", rmToCache, m_on && t == MSG_RM);
    chk("wm_flag", wmToCache, m_on && t == MSG_WM);
    chk("inv_flag", invToCache, m_on && t == MSG_INV);
    chk("doneValid", doneValid, m_done);
    if (m_done) chk("doneType", doneType, m_done_type);
    chk("timeoutErr", timeoutErr, m_to);
  endtask

  // one clock: model reacts to inputs sampled at the edge, outputs checked 1ns later
  task automatic step();
    bit ack_s, pv_s, pre_ready, fin;
    logic [MW-1:0] pd;
    @(posedge clk);
    ack_s     = allowReadFromCache;
    pv_s      = reqValid && (reqType != MSG_NONE);
    pd        = {reqAddr, reqType};
    pre_ready = exp_q.size() < DEPTH;
    m_done    = 0;
    m_to      = 0;
    if (m_on) begin
      fin = 0;
      if (m_cur[MSGTYPEWIDTH-1:0] == MSG_INV || ack_s) begin
        fin = 1; m_done = 1; m_done_type = m_cur[MSGTYPEWIDTH-1:0];
      end else if (TO_EN && (m_age + 1 >= TIMEOUT)) begin
        fin = 1; m_to = 1;
      end else begin
        m_age++;
      end
      if (fin) begin
        m_on = 0;
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() > 0) begin
      m_on   = 1;
      m_cur  = exp_q[0];
      m_addr = m_cur[MW-1:MSGTYPEWIDTH];
      m_age  = 0;
    end
    if (pv_s && pre_ready) exp_q.push_back(pd);
    #1;
    if (havMsgToCache) hi_cnt++;
    check_outputs();
  endtask

  // driver: present one request for one edge
  task automatic push_req(input logic [ADDRWIDTH-1:0] a, input logic [MSGTYPEWIDTH-1:0] t);
    reqValid = 1'b1; reqAddr = a; reqType = t;
    step();
    reqValid = 1'b0;
  endtask

  initial begin
    model_reset();
    hi_cnt = 0;
    #1;
    check_outputs();
    chk("doneType_rst", doneType, 0);
    chk("state_rst", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) step();

    // single INV at addr 5: one cycle on the wire, done next cycle
    hi_cnt = 0;
    push_req(8'd5, MSG_INV);
    repeat (5) step();
    chk("inv_width", hi_cnt, 1);

    // RM at addr 9: ack high before SEND is ignored, held 4 cycles
    hi_cnt = 0;
    allowReadFromCache = 1'b1;
    push_req(8'd9, MSG_RM);
    step();
    allowReadFromCache = 1'b0;
    repeat (3) step();
    allowReadFromCache = 1'b1;
    step();
    allowReadFromCache = 1'b0;
    repeat (3) step();
    chk("rm_width", hi_cnt, 4);

    // five back-to-back pushes without acks: fifth is refused
    for (int i = 0; i < 5; i++) push_req(8'h20 + 8'(i), (i % 2 == 0) ? MSG_RM : MSG_WM);
    chk("full_ready", reqReady, 0);
    allowReadFromCache = 1'b1;
    repeat (12) step();
    allowReadFromCache = 1'b0;

    // type 0 is consumed without producing a message
    hi_cnt = 0;
    push_req(8'h33, MSG_NONE);
    repeat (4) step();
    chk("none_quiet", hi_cnt, 0);

    // reset while a WM is on the wire
    push_req(8'h44, MSG_WM);
    repeat (2) step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("doneType_rst2", doneType, 0);
    @(negedge clk) reset = 1'b1;
    hi_cnt = 0;
    repeat (5) step();
    chk("no_stale", hi_cnt, 0);

    // RM never acked followed by an INV
    push_req(8'h60, MSG_RM);
    push_req(8'h61, MSG_INV);
    repeat (24) step();
    allowReadFromCache = 1'b1;
    repeat (6) step();
    allowReadFromCache = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reqValid           = 1'($urandom_range(0, 1));
      reqType            = 2'($urandom_range(0, 3));
      reqAddr            = 8'($urandom_range(0, 255));
      allowReadFromCache = ($urandom_range(0, 3) == 0);
      step();
    end
    reqValid = 1'b0;
    allowReadFromCache = 1'b1;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
